// File: rtl/twiddle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | twiddle_gen : 4-lane W_4096^k twiddle generator, quarter-wave cos ROM, 3cy |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module twiddle_gen #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          EN,
  input  logic          INV,
  input  logic [11:0]   EXP0,
  input  logic [11:0]   EXP1,
  input  logic [11:0]   EXP2,
  input  logic [11:0]   EXP3,
  output logic          VLD,
  output logic [DW-1:0] TW_RE0,
  output logic [DW-1:0] TW_RE1,
  output logic [DW-1:0] TW_RE2,
  output logic [DW-1:0] TW_RE3,
  output logic [DW-1:0] TW_IM0,
  output logic [DW-1:0] TW_IM1,
  output logic [DW-1:0] TW_IM2,
  output logic [DW-1:0] TW_IM3
);

  localparam int     c_lanes = 4;
  localparam int     c_rom_n = 1025;
  localparam longint c_amp   = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint c_one   = 64'sd1 <<< 30;

  // round(c_amp*cos(pi*idx/2048)) by a Q30 Taylor series, evaluated at elaboration
  function automatic logic [DW-2:0] cos_q(input longint idx);
    longint x2, term, acc, val;
    x2   = (64'sd3373259426 * idx) / 64'sd2048;
    x2   = (x2 * x2) >>> 30;
    term = c_one;
    acc  = c_one;
    for (longint n = 1; n <= 8; n++) begin
      term = -(((term * x2) >>> 30) / ((64'sd2 * n - 64'sd1) * (64'sd2 * n)));
      acc  = acc + term;
    end
    val = (acc * c_amp + (c_one >>> 1)) >>> 30;
    if (val < 64'sd0) val = 64'sd0;
    if (val > c_amp)  val = c_amp;
    return val[DW-2:0];
  endfunction

  function automatic logic [DW-1:0] ext(input logic [DW-2:0] v);
    return {1'b0, v};
  endfunction

  logic [DW-2:0] w_rom [c_rom_n];

  for (genvar gi = 0; gi < c_rom_n; gi++) begin : g_rom
    localparam logic [DW-2:0] c_val = cos_q(longint'(gi));
    assign w_rom[gi] = c_val;
  end

  logic [11:0]   w_exp [c_lanes];
  logic [DW-1:0] w_re  [c_lanes];
  logic [DW-1:0] w_im  [c_lanes];

  assign w_exp[0] = EXP0;
  assign w_exp[1] = EXP1;
  assign w_exp[2] = EXP2;
  assign w_exp[3] = EXP3;

  logic          r_s1_vld, r_s1_inv;
  logic [1:0]    r_s1_q  [c_lanes];
  logic [10:0]   r_s1_ac [c_lanes];
  logic [10:0]   r_s1_as [c_lanes];
  logic          r_s2_vld, r_s2_inv;
  logic [1:0]    r_s2_q  [c_lanes];
  logic [DW-2:0] r_s2_c  [c_lanes];
  logic [DW-2:0] r_s2_s  [c_lanes];
  logic          r_s3_vld;
  logic [DW-1:0] r_s3_re [c_lanes];
  logic [DW-1:0] r_s3_im [c_lanes];

  // Data registers only advance behind a valid bit so outputs hold across bubbles
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1_vld <= 1'b0;
      r_s1_inv <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_inv <= 1'b0;
      r_s3_vld <= 1'b0;
      for (int l = 0; l < c_lanes; l++) begin
        r_s1_q[l]  <= '0;
        r_s1_ac[l] <= '0;
        r_s1_as[l] <= '0;
        r_s2_q[l]  <= '0;
        r_s2_c[l]  <= '0;
        r_s2_s[l]  <= '0;
        r_s3_re[l] <= '0;
        r_s3_im[l] <= '0;
      end
    end else begin
      r_s1_vld <= EN;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      if (EN) begin
        r_s1_inv <= INV;
        for (int l = 0; l < c_lanes; l++) begin
          r_s1_q[l]  <= w_exp[l][11:10];
          r_s1_ac[l] <= {1'b0, w_exp[l][9:0]};
          r_s1_as[l] <= 11'd1024 - {1'b0, w_exp[l][9:0]};
        end
      end
      if (r_s1_vld) begin
        r_s2_inv <= r_s1_inv;
        for (int l = 0; l < c_lanes; l++) begin
          r_s2_q[l] <= r_s1_q[l];
          r_s2_c[l] <= w_rom[r_s1_ac[l]];
          r_s2_s[l] <= w_rom[r_s1_as[l]];
        end
      end
      if (r_s2_vld) begin
        for (int l = 0; l < c_lanes; l++) begin
          r_s3_re[l] <= w_re[l];
          r_s3_im[l] <= w_im[l];
        end
      end
    end
  end

  // Quadrant fold: C=cos(r), S=sin(r); conjugate applied after the fold
  always_comb begin
    for (int l = 0; l < c_lanes; l++) begin
      w_re[l] = '0;
      w_im[l] = '0;
      case (r_s2_q[l])
        2'd0: begin w_re[l] =  ext(r_s2_c[l]); w_im[l] = -ext(r_s2_s[l]); end
        2'd1: begin w_re[l] = -ext(r_s2_s[l]); w_im[l] = -ext(r_s2_c[l]); end
        2'd2: begin w_re[l] = -ext(r_s2_c[l]); w_im[l] =  ext(r_s2_s[l]); end
        default: begin w_re[l] = ext(r_s2_s[l]); w_im[l] = ext(r_s2_c[l]); end
      endcase
      if (r_s2_inv) w_im[l] = -w_im[l];
    end
  end

  assign VLD    = r_s3_vld;
  assign TW_RE0 = r_s3_re[0];
  assign TW_RE1 = r_s3_re[1];
  assign TW_RE2 = r_s3_re[2];
  assign TW_RE3 = r_s3_re[3];
  assign TW_IM0 = r_s3_im[0];
  assign TW_IM1 = r_s3_im[1];
  assign TW_IM2 = r_s3_im[2];
  assign TW_IM3 = r_s3_im[3];

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_twiddle_gen : directed stimulus, cos/sin golden model, literal pins     |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_twiddle_gen;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          EN = 1'b0;
  logic          INV = 1'b0;
  logic [11:0]   EXP0 = '0, EXP1 = '0, EXP2 = '0, EXP3 = '0;
  logic          VLD;
  logic [DW-1:0] TW_RE0, TW_RE1, TW_RE2, TW_RE3;
  logic [DW-1:0] TW_IM0, TW_IM1, TW_IM2, TW_IM3;

  always #5 CLK = ~CLK;

  twiddle_gen #(.DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .INV(INV),
    .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3),
    .VLD(VLD),
    .TW_RE0(TW_RE0), .TW_RE1(TW_RE1), .TW_RE2(TW_RE2), .TW_RE3(TW_RE3),
    .TW_IM0(TW_IM0), .TW_IM1(TW_IM1), .TW_IM2(TW_IM2), .TW_IM3(TW_IM3)
  );

  int checks = 0;
  int errors = 0;

  // Sample history indexed by clock-edge number since time zero
  int cyc   = 0;
  int start = 0;
  bit en_h  [4096];
  bit inv_h [4096];
  int k_h   [4096][4];
  int last_re [4] = '{0, 0, 0, 0};
  int last_im [4] = '{0, 0, 0, 0};

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int gold_re(int k);
    return rnd(32767.0 * $cos(6.283185307179586 * k / 4096.0));
  endfunction

  function automatic int gold_im(int k, bit inv);
    int v;
    v = rnd(-32767.0 * $sin(6.283185307179586 * k / 4096.0));
    return inv ? -v : v;
  endfunction

  function automatic int dut_re(int l);
    case (l)
      0: return int'($signed(TW_RE0));
      1: return int'($signed(TW_RE1));
      2: return int'($signed(TW_RE2));
      default: return int'($signed(TW_RE3));
    endcase
  endfunction

  function automatic int dut_im(int l);
    case (l)
      0: return int'($signed(TW_IM0));
      1: return int'($signed(TW_IM1));
      2: return int'($signed(TW_IM2));
      default: return int'($signed(TW_IM3));
    endcase
  endfunction

  task automatic chk(input string name, input int lane, input int got, input int exp, input int tol);
    checks++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      errors++;
      $display("FAIL %s lane %0d got %0d expected %0d (t=%0t)", name, lane, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input int lane, input int re, input int im);
    chk({name, "_re"}, lane, dut_re(lane), re, 0);
    chk({name, "_im"}, lane, dut_im(lane), im, 0);
  endtask

  task automatic drive(input bit en, input bit inv, input int k0, input int k1, input int k2, input int k3);
    @(posedge CLK);
    #1;
    EN   = en;
    INV  = inv;
    EXP0 = 12'(k0);
    EXP1 = 12'(k1);
    EXP2 = 12'(k2);
    EXP3 = 12'(k3);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 4095),
                     $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
  endtask

  always @(posedge CLK) begin
    if (RSTn) begin
      en_h[cyc]   = EN;
      inv_h[cyc]  = INV;
      k_h[cyc][0] = int'(EXP0);
      k_h[cyc][1] = int'(EXP1);
      k_h[cyc][2] = int'(EXP2);
      k_h[cyc][3] = int'(EXP3);
      cyc++;
    end
  end

  always @(negedge RSTn) begin
    start = cyc;
    for (int l = 0; l < 4; l++) begin
      last_re[l] = 0;
      last_im[l] = 0;
    end
  end

  // Output after edge c must reflect the sample taken two edges earlier
  always @(negedge CLK) begin
    int src;
    bit ev;
    if (RSTn && cyc > 0) begin
      src = cyc - 3;
      ev  = (src >= start) ? en_h[src] : 1'b0;
      chk("vld", -1, int'(VLD), int'(ev), 0);
      for (int l = 0; l < 4; l++) begin
        if (ev) begin
          last_re[l] = gold_re(k_h[src][l]);
          last_im[l] = gold_im(k_h[src][l], inv_h[src]);
          chk("model_re", l, dut_re(l), last_re[l], 1);
          chk("model_im", l, dut_im(l), last_im[l], 1);
        end else begin
          chk("hold_re", l, dut_re(l), last_re[l], 1);
          chk("hold_im", l, dut_im(l), last_im[l], 1);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_vld", -1, int'(VLD), 0, 0);
    for (int l = 0; l < 4; l++) lit("rst", l, 0, 0);
    RSTn = 1'b1;
    idle(2);

    // T1: quadrant corners, single pulse
    drive(1'b1, 1'b0, 0, 1024, 2048, 3072);
    idle(3);
    chk("t1_vld", -1, int'(VLD), 1, 0);
    lit("t1", 0,  32767,      0);
    lit("t1", 1,      0, -32767);
    lit("t1", 2, -32767,      0);
    lit("t1", 3,      0,  32767);
    idle(1);
    chk("t1_vld_off", -1, int'(VLD), 0, 0);
    idle(2);

    // T2 forward then T3 inverse on consecutive cycles
    drive(1'b1, 1'b0, 512, 1536, 2560, 3584);
    drive(1'b1, 1'b1, 512, 1536, 2560, 3584);
    idle(2);
    lit("t2", 0,  23170, -23170);
    lit("t2", 1, -23170, -23170);
    lit("t2", 2, -23170,  23170);
    lit("t2", 3,  23170,  23170);
    idle(1);
    lit("t3", 0,  23170,  23170);
    lit("t3", 1, -23170,  23170);
    lit("t3", 2, -23170, -23170);
    lit("t3", 3,  23170, -23170);
    idle(3);

    // T4: full sweep, every k covered once across the lanes
    for (int i = 0; i < 1024; i++) drive(1'b1, 1'b0, 4*i, 4*i + 1, 4*i + 2, 4*i + 3);
    idle(4);

    // T5: bubble pattern with boundary exponents
    drive(1'b1, 1'b0, 100, 1300, 2222, 4000);
    drive(1'b0, 1'b1, 7, 7, 7, 7);
    drive(1'b1, 1'b1, 5, 1030, 3000, 4095);
    drive(1'b1, 1'b0, 1023, 1025, 2047, 3071);
    drive(1'b0, 1'b0, 4095, 0, 1024, 2048);
    idle(4);
    drive(1'b1, 1'b0, 777, 777, 777, 777);
    idle(4);

    // T6: asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095));
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk("t6_rst_vld", -1, int'(VLD), 0, 0);
    for (int l = 0; l < 4; l++) lit("t6_rst", l, 0, 0);
    idle(2);
    #3;
    RSTn = 1'b1;
    idle(5);
    chk("t6_post_vld", -1, int'(VLD), 0, 0);
    drive(1'b1, 1'b1, 1, 1025, 2049, 3073);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
